lbp_tile_engine: RTL and testbench

Parametrised Local Binary Pattern engine that reads an `IMG_W`×`IMG_H` grayscale frame from the gray memory and writes one 8-bit LBP code per interior pixel to the LBP memory. It is the next generation of the fixed 8×8 LBP block:
- generic frame size and pixel width;
- sliding 3×3 window that reuses six pixels, so steady state needs 3 reads per output instead of 9;
- start/busy handshake and a one-cycle registered write strobe;
- optional border fill.

It sits between the gray-image SRAM and the LBP result SRAM.

---
 rtl/lbp_tile_engine_if.sv | 26 ++
 rtl/lbp_tile_engine.sv | 257 +++++++++++++++++++++++++
 tb/tb_lbp_tile_engine.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lbp_tile_engine_if.sv
// Frame handshake plus gray-read and LBP-write buses of lbp_tile_engine.
// The engine connects through the master modport, the memories/controller through slave.
interface lbp_tile_engine_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic          start;
  logic          busy;
  logic          finish;
  logic [AW-1:0] gray_addr;
  logic          gray_req;
  logic [DW-1:0] gray_data;
  logic [AW-1:0] lbp_addr;
  logic          lbp_write;
  logic [7:0]    lbp_data;

  modport master (
    input  start, gray_data,
    output busy, finish, gray_addr, gray_req, lbp_addr, lbp_write, lbp_data
  );

  modport slave (
    output start, gray_data,
    input  busy, finish, gray_addr, gray_req, lbp_addr, lbp_write, lbp_data
  );
endinterface

// File: rtl/lbp_tile_engine.sv
// Sliding 3x3 LBP engine: one 8-bit code per interior pixel of an IMG_W x IMG_H frame.
// Define LBP_BORDER_FILL_EN to additionally write 8'h00 to every border pixel.
module lbp_tile_engine #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              reset,
  lbp_tile_engine_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_SHIFT,
    S_DRAIN,
    S_WRITE,
`ifdef LBP_BORDER_FILL_EN
    S_BORDER,
`endif
    S_DONE
  } state_t;

  localparam logic [AW-1:0] ZERO_C = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_C  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] W_C    = AW'(IMG_W);
  localparam logic [AW-1:0] X_LAST = AW'(IMG_W - 2);
  localparam logic [AW-1:0] Y_LAST = AW'(IMG_H - 2);
`ifdef LBP_BORDER_FILL_EN
  localparam logic [AW-1:0] W_MAX  = AW'(IMG_W - 1);
  localparam logic [AW-1:0] H_MAX  = AW'(IMG_H - 1);
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]    col_q, col_d, row_q, row_d;
  logic          cap_q, cap_d;
  logic [DW-1:0] win_q [9];
  logic [DW-1:0] win_d [9];
  logic          busy_q, busy_d, finish_q, finish_d;
  logic          gray_req_q, gray_req_d, lbp_write_q, lbp_write_d;
  logic [AW-1:0] gray_addr_q, gray_addr_d, lbp_addr_q, lbp_addr_d;
  logic [7:0]    lbp_data_q, lbp_data_d;
  logic [7:0]    code_s;
  logic [AW-1:0] rd_row_s, rd_col_s;
`ifdef LBP_BORDER_FILL_EN
  logic [1:0]    bph_q, bph_d;
  logic [AW-1:0] bi_q, bi_d;
`endif

  function automatic logic ge_f(input logic [DW-1:0] n, input logic [DW-1:0] c);
    return (n >= c);
  endfunction

  // Window is a 9-deep column-major shift register: three captures slide it one column.
  always_comb begin
    if (cap_q) begin
      for (int i = 0; i < 8; i++) win_d[i] = win_q[i+1];
      win_d[8] = bus.gray_data;
    end else begin
      for (int i = 0; i < 9; i++) win_d[i] = win_q[i];
    end
  end

  // Code is taken from the post-capture window so DRAIN can register it directly.
  always_comb begin
    code_s = {ge_f(win_d[8], win_d[4]), ge_f(win_d[5], win_d[4]),
              ge_f(win_d[2], win_d[4]), ge_f(win_d[7], win_d[4]),
              ge_f(win_d[1], win_d[4]), ge_f(win_d[6], win_d[4]),
              ge_f(win_d[3], win_d[4]), ge_f(win_d[0], win_d[4])};
  end

  // Next-state and position counters.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    col_d    = col_q;
    row_d    = row_q;
    finish_d = finish_q;
`ifdef LBP_BORDER_FILL_EN
    bph_d    = bph_q;
    bi_d     = bi_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_PRIME;
          x_d      = ONE_C;
          y_d      = ONE_C;
          col_d    = 2'd0;
          row_d    = 2'd0;
          finish_d = 1'b0;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_PRIME, S_SHIFT: begin
        if (row_q == 2'd2) begin
          row_d = 2'd0;
          if (col_q == 2'd2) begin
            state_d = S_DRAIN;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          row_d = row_q + 2'd1;
        end
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        if (x_q < X_LAST) begin
          x_d     = x_q + ONE_C;
          col_d   = 2'd2;
          row_d   = 2'd0;
          state_d = S_SHIFT;
        end else if (y_q < Y_LAST) begin
          x_d     = ONE_C;
          y_d     = y_q + ONE_C;
          col_d   = 2'd0;
          row_d   = 2'd0;
          state_d = S_PRIME;
        end else begin
`ifdef LBP_BORDER_FILL_EN
          state_d = S_BORDER;
          bph_d   = 2'd0;
          bi_d    = ZERO_C;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef LBP_BORDER_FILL_EN
      // Phases: 0 top row, 1 bottom row, 2 left column, 3 right column (corners skipped).
      S_BORDER: begin
        if (!bph_q[1]) begin
          if (bi_q == W_MAX) begin
            bph_d = bph_q + 2'd1;
            bi_d  = bph_q[0] ? ONE_C : ZERO_C;
          end else begin
            bi_d  = bi_q + ONE_C;
          end
        end else begin
          if (bi_q == Y_LAST) begin
            if (bph_q[0]) begin
              state_d = S_DONE;
            end else begin
              bph_d = 2'd3;
              bi_d  = ONE_C;
            end
          end else begin
            bi_d = bi_q + ONE_C;
          end
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE) begin
      finish_d = 1'b1;
    end else begin
      finish_d = finish_d;
    end
  end

  // Output registers are loaded from the next state so they line up with state_q.
  always_comb begin
    rd_row_s    = y_d + AW'(row_d) - ONE_C;
    rd_col_s    = x_d + AW'(col_d) - ONE_C;
    cap_d       = gray_req_q;
    gray_req_d  = (state_d == S_PRIME) || (state_d == S_SHIFT);
    busy_d      = !((state_d == S_IDLE) || (state_d == S_DONE));
    if (gray_req_d) begin
      gray_addr_d = rd_row_s * W_C + rd_col_s;
    end else begin
      gray_addr_d = ZERO_C;
    end
    if (state_d == S_WRITE) begin
      lbp_write_d = 1'b1;
      lbp_addr_d  = y_d * W_C + x_d;
      lbp_data_d  = code_s;
    end
`ifdef LBP_BORDER_FILL_EN
    else if (state_d == S_BORDER) begin
      lbp_write_d = 1'b1;
      lbp_data_d  = 8'h00;
      case (bph_d)
        2'd0:    lbp_addr_d = bi_d;
        2'd1:    lbp_addr_d = H_MAX * W_C + bi_d;
        2'd2:    lbp_addr_d = bi_d * W_C;
        2'd3:    lbp_addr_d = bi_d * W_C + W_MAX;
        default: lbp_addr_d = ZERO_C;
      endcase
    end
`endif
    else begin
      lbp_write_d = 1'b0;
      lbp_addr_d  = ZERO_C;
      lbp_data_d  = 8'h00;
    end
  end

  // State, counters, window and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_q         <= ZERO_C;
      y_q         <= ZERO_C;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      cap_q       <= 1'b0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= ZERO_C;
      lbp_write_q <= 1'b0;
      lbp_addr_q  <= ZERO_C;
      lbp_data_q  <= 8'h00;
`ifdef LBP_BORDER_FILL_EN
      bph_q       <= 2'd0;
      bi_q        <= ZERO_C;
`endif
      for (int i = 0; i < 9; i++) win_q[i] <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cap_q       <= cap_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
      gray_req_q  <= gray_req_d;
      gray_addr_q <= gray_addr_d;
      lbp_write_q <= lbp_write_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
`ifdef LBP_BORDER_FILL_EN
      bph_q       <= bph_d;
      bi_q        <= bi_d;
`endif
      for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.finish    = finish_q;
  assign bus.gray_req  = gray_req_q;
  assign bus.gray_addr = gray_addr_q;
  assign bus.lbp_write = lbp_write_q;
  assign bus.lbp_addr  = lbp_addr_q;
  assign bus.lbp_data  = lbp_data_q;

endmodule

// File: tb/tb_lbp_tile_engine.sv
// Directed bench for lbp_tile_engine: an 8x8 instance and a 16x4 instance, each backed by a
// one-cycle-latency gray memory model, with writes collected for table-driven checks.
module tb_lbp_tile_engine;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   tick = 0;
  int   clash = 0;

`ifdef LBP_BORDER_FILL_EN
  localparam int LAT_A = 245;
  localparam int LAT_B = 189;
  localparam int NW_A  = 64;
  localparam int NW_B  = 64;
`else
  localparam int LAT_A = 217;
  localparam int LAT_B = 153;
  localparam int NW_A  = 36;
  localparam int NW_B  = 28;
`endif

  lbp_tile_engine_if #(.AW(6), .DW(8)) if_a ();
  lbp_tile_engine_if #(.AW(6), .DW(8)) if_b ();

  lbp_tile_engine #(.IMG_W(8),  .IMG_H(8), .DW(8), .AW(6)) u_dut_a (.clk(clk), .reset(reset), .bus(if_a));
  lbp_tile_engine #(.IMG_W(16), .IMG_H(4), .DW(8), .AW(6)) u_dut_b (.clk(clk), .reset(reset), .bus(if_b));

  logic [7:0] mem_a [64];
  logic [7:0] mem_b [64];
  logic [7:0] res_a [64];
  logic [7:0] res_b [64];
  int wq_a [$];
  int wq_b [$];
  int wc_a [$];
  int wc_b [$];

  typedef struct {
    int         img;
    int         addr;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [$];

  always #5 clk = ~clk;

  always @(posedge clk) tick <= tick + 1;

  always @(posedge clk) begin
    if (if_a.gray_req) if_a.gray_data <= mem_a[if_a.gray_addr];
    if (if_b.gray_req) if_b.gray_data <= mem_b[if_b.gray_addr];
  end

  always @(negedge clk) begin
    if (if_a.lbp_write) begin
      res_a[if_a.lbp_addr] = if_a.lbp_data;
      wq_a.push_back(int'(if_a.lbp_addr));
      wc_a.push_back(tick);
      if (if_a.gray_req) clash++;
    end
    if (if_b.lbp_write) begin
      res_b[if_b.lbp_addr] = if_b.lbp_data;
      wq_b.push_back(int'(if_b.lbp_addr));
      wc_b.push_back(tick);
      if (if_b.gray_req) clash++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) if_a.start = v;
    else          if_b.start = v;
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? if_a.busy : if_b.busy;
  endfunction

  function automatic logic get_finish(input int sel);
    return (sel == 0) ? if_a.finish : if_b.finish;
  endfunction

  task automatic clear_results();
    for (int i = 0; i < 64; i++) begin
      res_a[i] = 8'h11;
      res_b[i] = 8'h11;
    end
    wq_a.delete(); wq_b.delete(); wc_a.delete(); wc_b.delete();
    clash = 0;
  endtask

  task automatic load_img(input int img);
    for (int i = 0; i < 64; i++) begin
      case (img)
        0:       mem_a[i] = 8'h40;
        1:       mem_a[i] = 8'(i);
        2:       mem_a[i] = (i == 27) ? 8'h00 : 8'hFF;
        3:       mem_b[i] = 8'h40;
        default: mem_b[i] = (i == 37) ? 8'h00 : 8'hFF;
      endcase
    end
  endtask

  task automatic run_frame(input int sel, input bit poke_busy, input bit poke_done);
    int cyc, fin, t1, w, n, exp_lat, exp_nw;
    w       = (sel == 0) ? 8 : 16;
    exp_lat = (sel == 0) ? LAT_A : LAT_B;
    exp_nw  = (sel == 0) ? NW_A : NW_B;
    clear_results();
    @(negedge clk); set_start(sel, 1'b1);
    @(posedge clk);
    @(negedge clk); set_start(sel, 1'b0);
    t1 = tick; cyc = 1; fin = 0;
    chk("busy_after_start", get_busy(sel), 1);
    chk("finish_cleared", get_finish(sel), 0);
    while (fin == 0 && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (poke_busy && cyc == 40) set_start(sel, 1'b1);
      if (poke_busy && cyc == 41) set_start(sel, 1'b0);
      if (get_finish(sel)) fin = cyc;
    end
    chk("finish_latency", fin, exp_lat);
    chk("busy_at_finish", get_busy(sel), 0);
    if (poke_done) begin
      set_start(sel, 1'b1);
      @(negedge clk); set_start(sel, 1'b0);
      @(negedge clk);
      chk("start_in_done_ignored", get_busy(sel), 0);
      chk("finish_held", get_finish(sel), 1);
    end
    n = (sel == 0) ? wq_a.size() : wq_b.size();
    chk("write_count", n, exp_nw);
    chk("req_write_clash", clash, 0);
    if (sel == 0) begin
      chk("first_write_cycle", wc_a[0] - t1 + 1, 11);
      chk("steady_spacing", wc_a[1] - wc_a[0], 5);
      chk("row_start_spacing", wc_a[w-2] - wc_a[w-3], 11);
    end else begin
      chk("first_write_cycle", wc_b[0] - t1 + 1, 11);
      chk("steady_spacing", wc_b[1] - wc_b[0], 5);
      chk("row_start_spacing", wc_b[w-2] - wc_b[w-3], 11);
    end
  endtask

  task automatic check_seq(input int sel);
    int w, h, bad;
    int exp_q [$];
    int got_q [$];
    w = (sel == 0) ? 8 : 16;
    h = (sel == 0) ? 8 : 4;
    for (int y = 1; y <= h - 2; y++)
      for (int x = 1; x <= w - 2; x++) exp_q.push_back(y * w + x);
`ifdef LBP_BORDER_FILL_EN
    for (int x = 0; x < w; x++) exp_q.push_back(x);
    for (int x = 0; x < w; x++) exp_q.push_back((h - 1) * w + x);
    for (int y = 1; y <= h - 2; y++) exp_q.push_back(y * w);
    for (int y = 1; y <= h - 2; y++) exp_q.push_back(y * w + w - 1);
`endif
    if (sel == 0) got_q = wq_a;
    else          got_q = wq_b;
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] != exp_q[i]) bad++;
    chk("addr_sequence", bad, 0);
  endtask

  task automatic check_table(input int img);
    logic [7:0] got;
    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].img == img) begin
        got = (img < 3) ? res_a[vecs[k].addr] : res_b[vecs[k].addr];
        chk($sformatf("code img%0d addr%0d", img, vecs[k].addr), got, vecs[k].exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    clear_results();

    vecs.push_back('{img: 0, addr: 9,  exp: 8'hFF});
    vecs.push_back('{img: 0, addr: 30, exp: 8'hFF});
    vecs.push_back('{img: 0, addr: 54, exp: 8'hFF});
    vecs.push_back('{img: 1, addr: 9,  exp: 8'hF0});
    vecs.push_back('{img: 1, addr: 36, exp: 8'hF0});
    vecs.push_back('{img: 1, addr: 54, exp: 8'hF0});
    vecs.push_back('{img: 2, addr: 27, exp: 8'hFF});
    vecs.push_back('{img: 2, addr: 18, exp: 8'h7F});
    vecs.push_back('{img: 2, addr: 19, exp: 8'hBF});
    vecs.push_back('{img: 2, addr: 20, exp: 8'hDF});
    vecs.push_back('{img: 2, addr: 26, exp: 8'hEF});
    vecs.push_back('{img: 2, addr: 28, exp: 8'hF7});
    vecs.push_back('{img: 2, addr: 34, exp: 8'hFB});
    vecs.push_back('{img: 2, addr: 35, exp: 8'hFD});
    vecs.push_back('{img: 2, addr: 36, exp: 8'hFE});
    vecs.push_back('{img: 2, addr: 45, exp: 8'hFF});
    vecs.push_back('{img: 3, addr: 17, exp: 8'hFF});
    vecs.push_back('{img: 3, addr: 30, exp: 8'hFF});
    vecs.push_back('{img: 3, addr: 46, exp: 8'hFF});
    vecs.push_back('{img: 4, addr: 37, exp: 8'hFF});
    vecs.push_back('{img: 4, addr: 20, exp: 8'h7F});
    vecs.push_back('{img: 4, addr: 21, exp: 8'hBF});
    vecs.push_back('{img: 4, addr: 22, exp: 8'hDF});
    vecs.push_back('{img: 4, addr: 36, exp: 8'hEF});
    vecs.push_back('{img: 4, addr: 38, exp: 8'hF7});

    repeat (3) @(negedge clk);
    chk("reset_outputs_a", {if_a.busy, if_a.finish, if_a.gray_req, if_a.gray_addr,
                            if_a.lbp_write, if_a.lbp_addr, if_a.lbp_data}, 0);
    chk("reset_outputs_b", {if_b.busy, if_b.finish, if_b.gray_req, if_b.gray_addr,
                            if_b.lbp_write, if_b.lbp_addr, if_b.lbp_data}, 0);
    reset = 1'b0;

    for (int img = 0; img < 5; img++) begin
      load_img(img);
      run_frame((img < 3) ? 0 : 1, img == 1, img == 0 || img == 3);
      check_seq((img < 3) ? 0 : 1);
      check_table(img);
`ifdef LBP_BORDER_FILL_EN
      if (img == 0) chk("border_fill_a", res_a[0], 8'h00);
      if (img == 3) chk("border_fill_b", res_b[63], 8'h00);
`else
      if (img == 0) chk("border_untouched_a", res_a[0], 8'h11);
      if (img == 3) chk("border_untouched_b", res_b[63], 8'h11);
`endif
    end

    // Reset in the middle of a flat-image frame, then a clean rerun.
    load_img(0);
    clear_results();
    @(negedge clk); if_a.start = 1'b1;
    @(posedge clk);
    @(negedge clk); if_a.start = 1'b0;
    for (int cyc = 2; cyc <= 100; cyc++) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midframe_reset_outputs", {if_a.busy, if_a.finish, if_a.gray_req, if_a.gray_addr,
                                   if_a.lbp_write, if_a.lbp_addr, if_a.lbp_data}, 0);
    chk("writes_before_reset", wq_a.size(), 16);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clear_results();
    repeat (50) @(negedge clk);
    chk("no_write_after_reset", wq_a.size(), 0);
    chk("idle_after_reset", {if_a.busy, if_a.finish, if_a.gray_req}, 0);

    run_frame(0, 1'b1, 1'b0);
    check_seq(0);
    check_table(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
